// File: rtl/mipi_csi_rx_packet_decoder_gen.sv
// mipi_csi_rx_packet_decoder_gen: CSI-2 header/ECC check, VC/DT filter, short-packet strobes, payload stripping
module mipi_csi_rx_packet_decoder_gen #(
    parameter int          LANES          = 4,
    parameter int          MIPI_GEAR      = 8,
    parameter logic [15:0] DT_ACCEPT_MASK = 16'h3C00
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [3:0]         vc_mask_i,
    input  logic               data_valid_i,
    input  logic [8*LANES-1:0] data_i,
    output logic [8*LANES-1:0] data_o,
    output logic               output_valid_o,
    output logic [LANES-1:0]   byte_en_o,
    output logic               packet_last_o,
    output logic [5:0]         packet_type_o,
    output logic [1:0]         vc_o,
    output logic [15:0]        packet_length_o,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic               line_start_o,
    output logic               line_end_o,
    output logic               ecc_err_o,
    output logic               trunc_err_o
);
    localparam int W  = 8 * LANES;
    localparam int NW = 4 / LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4) || MIPI_GEAR != 8) begin : g_bad_cfg
        $error("LANES must be 1, 2 or 4 and MIPI_GEAR must be 8");
    end

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

    state_t           state, state_nx;
    logic [1:0]       cnt, cnt_nx;
    logic [15:0]      rem, rem_nx;
    logic [31:0]      h;
    logic [5:0]       dt;
    logic [1:0]       vc;
    logic [15:0]      wc;
    logic             hdr_done, ecc_bad, vc_ok, short_ok, long_ok, pay, last;
    logic [LANES-1:0] be;
    logic [3:0]       strb;
    logic [5:0]       meta_dt;
    logic [1:0]       meta_vc;
    logic [15:0]      meta_wc;
    logic             s1_v, s1_last, s1_ecc, s1_trunc;
    logic [LANES-1:0] s1_be;
    logic [W-1:0]     s1_data;
    logic [3:0]       s1_strb;

    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        hdr_ecc = {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                   ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    // h is the full 4-byte header whenever the current word completes it
    if (LANES == 4) begin : g_hdr_word
        assign h = data_i;
    end else begin : g_hdr_shift
        logic [31-W:0] hdr;
        assign h = {data_i, hdr};
        always_ff @(posedge clk_i or negedge reset_n_i)
            if (!reset_n_i) hdr <= '0;
            else if (data_valid_i) hdr <= h[31:W];
    end

    assign dt       = h[5:0];
    assign vc       = h[7:6];
    assign wc       = h[23:8];
    assign hdr_done = data_valid_i && (state == IDLE || state == HDR) && cnt == 2'(NW - 1);
    assign ecc_bad  = h[31:24] != {2'b00, hdr_ecc(h[23:0])};
    assign vc_ok    = vc_mask_i[vc];
    assign short_ok = hdr_done && !ecc_bad && dt[5:4] == 2'b00 && vc_ok;
    assign long_ok  = hdr_done && !ecc_bad && vc_ok && dt[5:4] == 2'b10 && DT_ACCEPT_MASK[dt[3:0]] && wc != 16'd0;
    assign strb     = (short_ok && dt[3:2] == 2'b00) ? 4'b0001 << dt[1:0] : 4'b0000;
    assign pay      = state == PAYLOAD && data_valid_i;
    assign last     = rem <= 16'(LANES);

    // lanes below the remaining byte count are valid; all ones until the final word
    always_comb begin
        be = '0;
        for (int i = 0; i < LANES; i++) be[i] = rem > 16'(i);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rem_nx   = rem;
        if (!data_valid_i) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (hdr_done) begin
            state_nx = long_ok ? PAYLOAD : DRAIN;
            cnt_nx   = '0;
            rem_nx   = wc;
        end else if (state == IDLE || state == HDR) begin
            state_nx = HDR;
            cnt_nx   = cnt + 2'd1;
        end else if (state == PAYLOAD) begin
            state_nx = last ? DRAIN : PAYLOAD;
            rem_nx   = last ? 16'd0 : rem - 16'(LANES);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            cnt             <= '0;
            rem             <= '0;
            meta_dt         <= '0;
            meta_vc         <= '0;
            meta_wc         <= '0;
            s1_v            <= 1'b0;
            s1_last         <= 1'b0;
            s1_be           <= '0;
            s1_data         <= '0;
            s1_strb         <= '0;
            s1_ecc          <= 1'b0;
            s1_trunc        <= 1'b0;
            data_o          <= '0;
            output_valid_o  <= 1'b0;
            byte_en_o       <= '0;
            packet_last_o   <= 1'b0;
            packet_type_o   <= '0;
            vc_o            <= '0;
            packet_length_o <= '0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            ecc_err_o       <= 1'b0;
            trunc_err_o     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rem      <= rem_nx;
            if (long_ok) {meta_dt, meta_vc, meta_wc} <= {dt, vc, wc};
            s1_v     <= pay;
            s1_last  <= pay && last;
            s1_be    <= be;
            s1_data  <= data_i;
            s1_strb  <= strb;
            s1_ecc   <= hdr_done && ecc_bad;
            s1_trunc <= state == PAYLOAD && !data_valid_i;
            data_o         <= s1_data;
            output_valid_o <= s1_v;
            byte_en_o      <= s1_v ? s1_be : '0;
            packet_last_o  <= s1_last;
            frame_start_o  <= s1_strb[0];
            frame_end_o    <= s1_strb[1];
            line_start_o   <= s1_strb[2];
            line_end_o     <= s1_strb[3];
            ecc_err_o      <= s1_ecc;
            trunc_err_o    <= s1_trunc;
            if (s1_v) begin
                packet_type_o   <= meta_dt;
                vc_o            <= meta_vc;
                packet_length_o <= meta_wc;
            end
        end
    end
endmodule
